// File: rtl/clk_div_bank.sv
// clk_div_bank: N-channel programmable clock divider bank.
// Each channel produces a registered divided clock and a one-cycle tick at
// every period start. Divisors are reloaded at runtime through a valid/ready
// port, and a sync input restarts every channel at phase 0.
// Optional feature macro: CLK_DIV_BANK_GLITCHFREE_EN
//   defined   - loads are held in a shadow register and applied at the next
//               period boundary (or sync), with backpressure while pending.
//   undefined - loads apply on the next edge and restart the channel.
module clk_div_bank #(
  parameter int unsigned                CHANNELS = 3,
  parameter int unsigned                WIDTH    = 16,
  parameter logic [CHANNELS*WIDTH-1:0]  DIV_INIT = {16'd594, 16'd13750, 16'd594},
  localparam int unsigned               CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic                sync,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [CHW-1:0]      load_ch,
  input  logic [WIDTH-1:0]    load_div,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pending
);

  logic [WIDTH-1:0]    cnt_q [CHANNELS];
  logic [WIDTH-1:0]    cnt_d [CHANNELS];
  logic [WIDTH-1:0]    div_q [CHANNELS];
  logic [WIDTH-1:0]    div_d [CHANNELS];
  logic [CHANNELS-1:0] clk_q;
  logic [CHANNELS-1:0] clk_d;
  logic [CHANNELS-1:0] tick_q;
  logic [CHANNELS-1:0] tick_d;

`ifdef CLK_DIV_BANK_GLITCHFREE_EN
  logic [WIDTH-1:0]    shadow_q [CHANNELS];
  logic [WIDTH-1:0]    shadow_d [CHANNELS];
  logic [CHANNELS-1:0] pend_q;
  logic [CHANNELS-1:0] pend_d;
  logic                load_fire;

  // Backpressure only the targeted channel while it still holds a divisor.
  always_comb begin
    load_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (load_ch == CHW'(i)) load_ready = ~pend_q[i];
    end
  end

  assign load_fire = load_valid && load_ready;
  assign pending   = pend_q;
`else
  assign load_ready = 1'b1;
  assign pending    = '0;
`endif

  assign clk_out = clk_q;
  assign tick    = tick_q;

  // Next-state for every channel: counting, wrap, divisor application, loads.
  always_comb begin
    logic             wrap;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] d_eff;
    cnt_d  = cnt_q;
    div_d  = div_q;
    clk_d  = clk_q;
    tick_d = '0;
`ifdef CLK_DIV_BANK_GLITCHFREE_EN
    shadow_d = shadow_q;
    pend_d   = pend_q;
`endif
    for (int i = 0; i < CHANNELS; i++) begin
      wrap  = 1'b0;
      nxt   = cnt_q[i];
      d_eff = div_q[i];
      if (sync) begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
`ifdef CLK_DIV_BANK_GLITCHFREE_EN
        if (pend_q[i]) begin
          div_d[i]  = shadow_q[i];
          pend_d[i] = 1'b0;
        end
`endif
      end else if (div_q[i] == '0) begin
        // Stopped channel: parked low at phase 0.
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
`ifdef CLK_DIV_BANK_GLITCHFREE_EN
        if (pend_q[i]) begin
          div_d[i]  = shadow_q[i];
          pend_d[i] = 1'b0;
        end
`endif
      end else if (!en[i]) begin
        // Frozen channel: no period boundary will come, so apply now.
`ifdef CLK_DIV_BANK_GLITCHFREE_EN
        if (pend_q[i]) begin
          div_d[i]  = shadow_q[i];
          pend_d[i] = 1'b0;
        end
`endif
      end else begin
        // A count beyond the end (after a divisor shrink) wraps immediately.
        wrap = (cnt_q[i] >= (div_q[i] - WIDTH'(1)));
        nxt  = wrap ? '0 : (cnt_q[i] + WIDTH'(1));
`ifdef CLK_DIV_BANK_GLITCHFREE_EN
        if (wrap && pend_q[i]) begin
          d_eff     = shadow_q[i];
          div_d[i]  = shadow_q[i];
          pend_d[i] = 1'b0;
        end
`endif
        cnt_d[i]  = nxt;
        clk_d[i]  = (d_eff != '0) && (nxt >= (d_eff >> 1));
        tick_d[i] = wrap;
      end
`ifdef CLK_DIV_BANK_GLITCHFREE_EN
      if (load_fire && (load_ch == CHW'(i))) begin
        pend_d[i]   = 1'b1;
        shadow_d[i] = load_div;
      end
`else
      if (load_valid && (load_ch == CHW'(i))) begin
        div_d[i]  = load_div;
        cnt_d[i]  = '0;
        clk_d[i]  = 1'b0;
        tick_d[i] = 1'b0;
      end
`endif
    end
  end

  // State registers with synchronous reset to the initial divisors.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= DIV_INIT[i*WIDTH +: WIDTH];
`ifdef CLK_DIV_BANK_GLITCHFREE_EN
        shadow_q[i] <= '0;
`endif
      end
      clk_q  <= '0;
      tick_q <= '0;
`ifdef CLK_DIV_BANK_GLITCHFREE_EN
      pend_q <= '0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
`ifdef CLK_DIV_BANK_GLITCHFREE_EN
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
`endif
    end
  end

endmodule
